branch_predict_ctrl: RTL and testbench

- Branch prediction and redirect controller for the pipelined RV32I core.
- Predicts conditional branches (opcode 7'd99) at fetch using a bimodal table of 2-bit saturating counters.
- Resolves each branch in EX using br_taken from the branch comparator, trains the table, and sequences the mispredict recovery: PC redirect plus front-end flush.
- Sits between fetch PC mux, IF/ID and ID/EX pipeline registers, and the EX-stage branch comparator.

---
 rtl/branch_predict_ctrl_if.sv | 40 ++++
 rtl/branch_predict_ctrl.sv | 84 ++++++++
 tb/tb_branch_predict_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/EX/redirect signal bundle between the core pipeline and the branch
// prediction controller.
interface branch_predict_ctrl_if #(
  parameter int REG_SIZE = 32
);
  logic                if_valid;
  logic [REG_SIZE-1:0] if_pc;
  logic [6:0]          if_opcode;
  logic [REG_SIZE-1:0] if_imm_b;
  logic                pred_taken;
  logic [REG_SIZE-1:0] pred_target;

  logic                ex_valid;
  logic [REG_SIZE-1:0] ex_pc;
  logic [6:0]          ex_opcode;
  logic                ex_pred_taken;
  logic                ex_br_taken;
  logic [REG_SIZE-1:0] ex_target;

  logic                redirect;
  logic [REG_SIZE-1:0] redirect_pc;
  logic                flush;
  logic [31:0]         br_count;
  logic [31:0]         mispred_count;

  // The pipeline side drives fetch/EX information and consumes predictions.
  modport master (
    output if_valid, if_pc, if_opcode, if_imm_b,
    output ex_valid, ex_pc, ex_opcode, ex_pred_taken, ex_br_taken, ex_target,
    input  pred_taken, pred_target, redirect, redirect_pc, flush,
    input  br_count, mispred_count
  );

  modport slave (
    input  if_valid, if_pc, if_opcode, if_imm_b,
    input  ex_valid, ex_pc, ex_opcode, ex_pred_taken, ex_br_taken, ex_target,
    output pred_taken, pred_target, redirect, redirect_pc, flush,
    output br_count, mispred_count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with EX-stage training and mispredict recovery
// (one-cycle redirect pulse plus a multi-cycle front-end flush).
module branch_predict_ctrl #(
  parameter int REG_SIZE     = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  branch_predict_ctrl_if.slave bus
);
  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'd99;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [1:0]       bht [BHT_ENTRIES];
  logic [2:0]       flush_cnt;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             mispredict;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];

  assign bus.pred_taken  = bus.if_valid && (bus.if_opcode == OP_BRANCH) && bht[if_idx][1];
  assign bus.pred_target = bus.pred_taken ? (bus.if_pc + bus.if_imm_b)
                                          : (bus.if_pc + REG_SIZE'(4));

  // EX results are only honoured in RUN; instructions seen during FLUSH are being killed.
  assign resolve    = bus.ex_valid && (bus.ex_opcode == OP_BRANCH) && (state == RUN);
  assign mispredict = resolve && (bus.ex_pred_taken != bus.ex_br_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      state             <= RUN;
      flush_cnt         <= '0;
      bus.redirect      <= 1'b0;
      bus.redirect_pc   <= '0;
      bus.flush         <= 1'b0;
      bus.br_count      <= '0;
      bus.mispred_count <= '0;
    end else begin
      if (resolve) begin
        if (bus.ex_br_taken) begin
          if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
        end else begin
          if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
        end
        bus.br_count <= bus.br_count + 32'd1;
      end

      case (state)
        RUN: begin
          if (mispredict) begin
            bus.redirect_pc   <= bus.ex_br_taken ? bus.ex_target
                                                 : (bus.ex_pc + REG_SIZE'(4));
            bus.redirect      <= 1'b1;
            bus.flush         <= 1'b1;
            flush_cnt         <= 3'(FLUSH_CYCLES - 1);
            bus.mispred_count <= bus.mispred_count + 32'd1;
            state             <= FLUSH;
          end else begin
            bus.redirect <= 1'b0;
            bus.flush    <= 1'b0;
          end
        end
        FLUSH: begin
          bus.redirect <= 1'b0;
          if (flush_cnt == 3'd0) begin
            bus.flush <= 1'b0;
            state     <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: prediction, training, saturation,
// mispredict recovery timing, aliasing, wrap-around and mid-flush reset.
module tb_branch_predict_ctrl;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  branch_predict_ctrl_if #(.REG_SIZE(32)) bus ();

  branch_predict_ctrl #(.REG_SIZE(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyFetch(input logic v, input logic [31:0] pc,
                            input logic [6:0] op, input logic [31:0] imm);
    bus.if_valid  = v;
    bus.if_pc     = pc;
    bus.if_opcode = op;
    bus.if_imm_b  = imm;
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [6:0] op,
                               input logic pred, input logic taken, input logic [31:0] tgt);
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_opcode     = op;
    bus.ex_pred_taken = pred;
    bus.ex_br_taken   = taken;
    bus.ex_target     = tgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRecovery(input string tag, input logic rd, input logic [31:0] rpc,
                               input logic fl, input logic [31:0] bc, input logic [31:0] mc);
    checkOutput({tag, ".redirect"},    32'(bus.redirect), 32'(rd));
    checkOutput({tag, ".redirect_pc"}, bus.redirect_pc,   rpc);
    checkOutput({tag, ".flush"},       32'(bus.flush),    32'(fl));
    checkOutput({tag, ".br_count"},    bus.br_count,      bc);
    checkOutput({tag, ".mispred"},     bus.mispred_count, mc);
  endtask

  initial begin
    rst_n = 1'b0;
    applyFetch(0, 32'h0, 7'd0, 32'h0);
    applyStimulus(0, 32'h0, 7'd0, 0, 0, 32'h0);
    tick();
    tick();
    checkRecovery("reset", 0, 32'h0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Fresh entry is weakly not-taken
    applyFetch(1, 32'h100, 7'd99, 32'h40);
    checkOutput("fetch0.pred_taken",  32'(bus.pred_taken), 32'd0);
    checkOutput("fetch0.pred_target", bus.pred_target,     32'h104);

    // First taken resolve mispredicts (entry 01 -> 10)
    applyStimulus(1, 32'h100, 7'd99, 0, 1, 32'h140);
    tick();
    checkRecovery("train1", 1, 32'h140, 1, 1, 1);
    applyStimulus(0, 32'h100, 7'd99, 0, 1, 32'h140);
    tick();
    checkRecovery("train1.f1", 0, 32'h140, 1, 1, 1);
    tick();
    checkRecovery("train1.f2", 0, 32'h140, 0, 1, 1);
    checkOutput("fetch1.pred_taken",  32'(bus.pred_taken), 32'd1);
    checkOutput("fetch1.pred_target", bus.pred_target,     32'h140);

    // Two correctly predicted taken resolves: 10 -> 11 -> 11
    applyStimulus(1, 32'h100, 7'd99, 1, 1, 32'h140);
    tick();
    checkRecovery("train2", 0, 32'h140, 0, 2, 1);
    tick();
    checkRecovery("train3", 0, 32'h140, 0, 3, 1);
    checkOutput("fetch3.pred_taken", 32'(bus.pred_taken), 32'd1);

    // Mispredict at 0x200 (same index, stays saturated)
    applyStimulus(1, 32'h200, 7'd99, 0, 1, 32'h180);
    tick();
    checkRecovery("mp200", 1, 32'h180, 1, 4, 2);
    // Branch during FLUSH must be ignored
    applyStimulus(1, 32'h100, 7'd99, 1, 0, 32'h140);
    tick();
    checkRecovery("mp200.f1", 0, 32'h180, 1, 4, 2);
    tick();
    checkRecovery("mp200.f2", 0, 32'h180, 0, 4, 2);
    applyFetch(1, 32'h140, 7'd99, 32'h40);
    checkOutput("noflushtrain.pred_taken",  32'(bus.pred_taken), 32'd1);
    checkOutput("noflushtrain.pred_target", bus.pred_target,     32'h180);
    // Back-to-back: resolve processed on the cycle FSM returns to RUN (11 -> 10)
    tick();
    checkRecovery("b2b", 1, 32'h104, 1, 5, 3);
    checkOutput("b2b.pred_taken", 32'(bus.pred_taken), 32'd1);
    applyStimulus(0, 32'h100, 7'd99, 1, 0, 32'h140);
    tick();
    tick();
    checkRecovery("b2b.done", 0, 32'h104, 0, 5, 3);

    // JAL is neither trained, counted nor predicted
    applyStimulus(1, 32'h100, 7'd111, 0, 1, 32'h300);
    tick();
    checkRecovery("jal", 0, 32'h104, 0, 5, 3);
    applyFetch(1, 32'h100, 7'd111, 32'h40);
    checkOutput("jal.pred_taken",  32'(bus.pred_taken), 32'd0);
    checkOutput("jal.pred_target", bus.pred_target,     32'h104);
    applyStimulus(0, 32'h0, 7'd0, 0, 0, 32'h0);

    // Wrap-around of PC+4 in both prediction and redirect
    applyFetch(1, 32'hFFFF_FFFC, 7'd99, 32'h40);
    checkOutput("wrap.pred_target", bus.pred_target, 32'h0);
    applyStimulus(1, 32'hFFFF_FFFC, 7'd99, 1, 0, 32'h3C);
    tick();
    checkRecovery("wrap", 1, 32'h0, 1, 6, 4);
    applyStimulus(0, 32'h0, 7'd0, 0, 0, 32'h0);
    tick();
    tick();

    // Train idx 5 to taken without mispredicting
    applyStimulus(1, 32'h114, 7'd99, 1, 1, 32'h200);
    tick();
    checkRecovery("idx5", 0, 32'h0, 0, 7, 4);
    applyStimulus(0, 32'h0, 7'd0, 0, 0, 32'h0);
    applyFetch(1, 32'h114, 7'd99, 32'h20);
    checkOutput("idx5.pred_taken",  32'(bus.pred_taken), 32'd1);
    checkOutput("idx5.pred_target", bus.pred_target,     32'h134);

    // Aliasing: training 0x140 flips 0x100; same-cycle fetch sees old value
    applyFetch(1, 32'h100, 7'd99, 32'h40);
    applyStimulus(1, 32'h140, 7'd99, 1, 0, 32'h180);
    checkOutput("alias.same_cycle", 32'(bus.pred_taken), 32'd1);
    tick();
    checkOutput("alias.after",        32'(bus.pred_taken), 32'd0);
    checkOutput("alias.after_target", bus.pred_target,     32'h104);
    checkRecovery("alias", 1, 32'h144, 1, 8, 5);
    applyStimulus(0, 32'h0, 7'd0, 0, 0, 32'h0);
    tick();

    // Reset during the second flush cycle
    checkOutput("preRst.flush", 32'(bus.flush), 32'd1);
    rst_n = 1'b0;
    #1;
    checkRecovery("midRst", 0, 32'h0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    applyFetch(1, 32'h114, 7'd99, 32'h20);
    checkOutput("postRst.pred_taken",  32'(bus.pred_taken), 32'd0);
    checkOutput("postRst.pred_target", bus.pred_target,     32'h118);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
